// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding imem req/ack fetch and small {pc, inst} buffer feeding decode.
// Optional INSTR_FETCH_MISALIGN_CHECK_EN halts on misaligned redirects and flags misalign_o.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    input  logic        inst_ready_i,
    output logic        misalign_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FETCH, DROP, HALT} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_n;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic            mis_q, mis_d;
    logic [63:0]     mem_pc [DEPTH];
    logic [31:0]     mem_inst [DEPTH];
    logic [63:0]     target;
    logic            bad, push, pop, done;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign target = redirect_pc_i;
    assign bad    = redirect_pc_i[1:0] != 2'b00;
`else
    assign target = redirect_pc_i & ~64'h3;
    assign bad    = 1'b0;
`endif

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = cnt_q != '0;
    assign inst_o       = inst_valid_o ? mem_inst[rd_q] : 32'h0000_0013;
    assign pc_o         = inst_valid_o ? mem_pc[rd_q] : 64'h0;
    assign misalign_o   = mis_q;

    always_comb begin
        pop     = inst_valid_o && inst_ready_i && !redirect_i;
        push    = imem_ack_i && req_q && state_q == FETCH && !redirect_i;
        done    = !req_q || imem_ack_i;
        cnt_n   = cnt_q + CW'(push) - CW'(pop);
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        if (redirect_i) begin
            pc_d  = target;
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            mis_d = bad;
            if (!done) begin
                state_d = DROP;
            end else begin
                state_d = bad ? HALT : FETCH;
                req_d   = !bad;
                addr_d  = target;
            end
        end else if (state_q == DROP) begin
            if (imem_ack_i) begin
                state_d = mis_q ? HALT : FETCH;
                req_d   = !mis_q;
                addr_d  = pc_q;
            end
        end else if (state_q == FETCH) begin
            cnt_d = cnt_n;
            rd_d  = rd_q + AW'(pop);
            wr_d  = wr_q + AW'(push);
            pc_d  = push ? pc_q + 64'd4 : pc_q;
            if (done) begin
                req_d  = cnt_n < CW'(DEPTH);
                addr_d = req_d ? pc_d : addr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_q]   <= addr_q;
            mem_inst[wr_q] <= imem_data_i;
        end
    end
endmodule
